clk_period_meter: RTL and testbench

- Measures an external or divided square-wave clock (e.g. the CPU slow clock, game tick) in the fast system-clock domain.
- It is the receiving end of a clock divider: it synchronizes the slow wave and detects its edges.
- It recovers period and high time in fast-clock cycles, and flags lock/loss of the wave.
- Used for on-board self-check of divider ratios and as a clean single-cycle tick source for fast-domain logic.

---
 rtl/clk_period_meter.sv | 166 ++++++++++++++++
 tb/tb_clk_period_meter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module  : clk_period_meter
// Purpose : Receives a slow square wave (divided clock, game tick, ...) in the
//           fast clk domain. Synchronizes it, detects its edges, measures
//           period and high time in clk cycles, and reports lock and loss.
// Ports   : clk        - system clock
//           reset      - asynchronous, active-low reset
//           sig_in     - asynchronous square wave to measure
//           clear      - synchronous restart (drops lock, back to IDLE)
//           rise_pulse - one-cycle pulse per synchronized rising edge
//           period     - last rise-to-rise interval, clk cycles
//           high_time  - last rise-to-fall interval, clk cycles
//           meas_valid - one-cycle pulse when period is updated
//           locked     - two consecutive equal periods seen
//           timeout    - sticky loss-of-wave flag
// Revision: 1.0 - initial release
// ============================================================================
module clk_period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clear,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_to_last  = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   rise_pulse_q, rise_pulse_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;
    // Set once a period has been measured since the last IDLE; a lock
    // decision needs a fresh previous period, not one left over from
    // before a clear or timeout.
    logic                   have_prev_q, have_prev_d;

    logic                   w_last;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W-1:0]       w_cnt_inc;

    assign w_last    = sync_q[SYNC_STAGES-1];
    assign w_rise    = w_last & ~prev_q;
    assign w_fall    = ~w_last & prev_q;
    // Saturating increment; also the interval length including this cycle.
    assign w_cnt_inc = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d       = w_last;
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        rise_pulse_d = 1'b0;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        have_prev_d  = have_prev_q;

        if (clear) begin
            state_d     = IDLE;
            cnt_d       = '0;
            locked_d    = 1'b0;
            timeout_d   = 1'b0;
            have_prev_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d       = '0;
                    have_prev_d = 1'b0;
                    // First rise only arms the meter.
                    if (w_rise) begin
                        state_d      = MEASURE;
                        rise_pulse_d = 1'b1;
                        timeout_d    = 1'b0;
                    end
                end
                MEASURE: begin
                    cnt_d = w_cnt_inc;
                    if (w_fall) begin
                        high_time_d = w_cnt_inc;
                    end
                    // A rise on the last allowed cycle still wins over loss.
                    if (w_rise) begin
                        period_d     = w_cnt_inc;
                        meas_valid_d = 1'b1;
                        rise_pulse_d = 1'b1;
                        cnt_d        = '0;
                        timeout_d    = 1'b0;
                        locked_d     = have_prev_q && (w_cnt_inc == period_q);
                        have_prev_d  = 1'b1;
                    end else if (cnt_q == c_to_last) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            rise_pulse_q <= 1'b0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            have_prev_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            rise_pulse_q <= rise_pulse_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            have_prev_q  <= have_prev_d;
        end
    end

    assign rise_pulse = rise_pulse_q;
    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_period_meter
// Purpose : Directed self-checking bench for clk_period_meter (TIMEOUT=64).
// Revision: 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic             sig_in;
    logic             clear;
    logic             rise_pulse;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        int          cyc;
        logic        rp;
        logic        mv;
        logic        lk;
        logic        to;
        logic [31:0] per;
        logic [31:0] hi;
    } ev_t;

    ev_t ev_q[$];

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .TIMEOUT    (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .clear     (clear),
        .rise_pulse(rise_pulse),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every cycle carrying a rise_pulse or meas_valid, sampled mid-cycle.
    always @(negedge clk) begin
        if (rise_pulse || meas_valid) begin
            ev_q.push_back('{cyc, rise_pulse, meas_valid, locked, timeout,
                             period, high_time});
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic ev_t ev(input int i);
        ev_t e;
        e = '{default: '0};
        if (i < ev_q.size()) e = ev_q[i];
        return e;
    endfunction

    task automatic drive_wave(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int t0;
        bit seen;

        reset  = 1'b0;
        sig_in = 1'b0;
        clear  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rise_pulse", rise_pulse, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_period",     period,     0);
        check("rst_high_time",  high_time,  0);
        check("rst_locked",     locked,     0);
        check("rst_timeout",    timeout,    0);

        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 4/4 wave: period 8, high 4
        ev_q.delete();
        drive_wave(4, 4, 4);
        check("p1_events",     ev_q.size(), 4);
        check("p1_r0_mv",      ev(0).mv, 0);
        check("p1_r1_mv",      ev(1).mv, 1);
        check("p1_r1_spacing", ev(1).cyc - ev(0).cyc, 8);
        check("p1_r1_period",  ev(1).per, 8);
        check("p1_r1_high",    ev(1).hi, 4);
        check("p1_r1_locked",  ev(1).lk, 0);
        check("p1_r2_locked",  ev(2).lk, 1);
        check("p1_r3_rp",      ev(3).rp, 1);
        check("p1_r3_mv",      ev(3).mv, 1);

        // 3/7 duty: period 10, high 3
        do_clear();
        ev_q.delete();
        drive_wave(3, 7, 4);
        check("p2_events",    ev_q.size(), 4);
        check("p2_r0_mv",     ev(0).mv, 0);
        check("p2_r1_period", ev(1).per, 10);
        check("p2_r1_high",   ev(1).hi, 3);
        check("p2_r1_locked", ev(1).lk, 0);
        check("p2_r2_locked", ev(2).lk, 1);

        // Wave stops low after 3 rises -> timeout 64 cycles after last pulse
        do_clear();
        ev_q.delete();
        drive_wave(4, 4, 3);
        check("p3_events", ev_q.size(), 3);
        seen = 1'b0;
        t0   = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (timeout) begin
                seen = 1'b1;
                t0   = cyc;
                break;
            end
        end
        check("p3_timeout_seen", seen, 1);
        check("p3_timeout_delay", t0 - ev(2).cyc, 64);
        check("p3_locked_after_to", locked, 0);
        check("p3_period_held", period, 8);
        ev_q.delete();
        drive_wave(4, 4, 3);
        check("p3_rearm_to",  ev(0).to, 0);
        check("p3_rearm_mv",  ev(0).mv, 0);
        check("p3_rearm_r1_mv", ev(1).mv, 1);
        check("p3_rearm_r1_lk", ev(1).lk, 0);

        // Period change 8 -> 12
        do_clear();
        ev_q.delete();
        drive_wave(4, 4, 3);
        drive_wave(6, 6, 3);
        check("p4_events",    ev_q.size(), 6);
        check("p4_r3_period", ev(3).per, 8);
        check("p4_r3_locked", ev(3).lk, 1);
        check("p4_r4_period", ev(4).per, 12);
        check("p4_r4_locked", ev(4).lk, 0);
        check("p4_r5_period", ev(5).per, 12);
        check("p4_r5_locked", ev(5).lk, 1);

        // clear coincident with the synchronized rise
        ev_q.delete();
        sig_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (5) @(negedge clk);
        check("p5_no_pulse",    ev_q.size(), 0);
        check("p5_period_held", period, 12);
        check("p5_locked",      locked, 0);
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        drive_wave(4, 4, 2);
        check("p5_idle_r0_mv", ev(0).mv, 0);
        check("p5_idle_r1_mv", ev(1).mv, 1);
        check("p5_idle_r1_per", ev(1).per, 8);

        // Asynchronous reset mid-period while locked
        do_clear();
        drive_wave(4, 4, 3);
        check("p6_locked_before", locked, 1);
        sig_in = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("p6_rst_period", period,     0);
        check("p6_rst_high",   high_time,  0);
        check("p6_rst_locked", locked,     0);
        check("p6_rst_to",     timeout,    0);
        check("p6_rst_rp",     rise_pulse, 0);
        check("p6_rst_mv",     meas_valid, 0);
        @(negedge clk);
        reset  = 1'b1;
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        ev_q.delete();
        drive_wave(4, 4, 3);
        check("p6_r0_mv",     ev(0).mv, 0);
        check("p6_r1_mv",     ev(1).mv, 1);
        check("p6_r1_period", ev(1).per, 8);
        check("p6_r1_high",   ev(1).hi, 4);
        check("p6_r2_locked", ev(2).lk, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
